coef_loader: RTL
================

// Module: coef_loader
// PURPOSE
//  Byte-stream frame receiver that drives the write port of the 8-filter coefficient memory bank.
//  Parses framed bytes from the serial interface (UART/SPI byte layer) into 36-bit coefficient words.
//  Issues one write per word: addressW/datain/we, incrementing address. Checksum and timeout are status only.
//  Sits between the serial byte receiver and the coefficient memory bank (512 x 36, addr[8:6] = bank).
// PARAMETERS
//  SYNC_BYTE       8'hA5   frame start marker, recognised only in IDLE
//  TIMEOUT_CYCLES  50000   max clocks between accepted bytes inside a frame before abort (>=2)
// PORTS
//  clock        in   1   master clock, posedge
//  reset_n      in   1   synchronous reset, active low
//  rx_data      in   8   received byte
//  rx_valid     in   1   rx_data valid this cycle
//  rx_ready     out  1   loader accepts byte; byte consumed when rx_valid && rx_ready
//  addressW     out  9   memory write address
//  datain       out  36  memory write data: two 18-bit coefficients, [35:18] | [17:0]
//  we           out  1   memory write enable, 1-cycle pulse per word
//  busy         out  1   high whenever state != IDLE
//  load_done    out  1   1-cycle pulse at end of a complete frame (checksum byte consumed)
//  csum_err     out  1   1-cycle pulse, coincident with load_done, when checksum mismatches
//  timeout_err  out  1   1-cycle pulse when a frame is aborted by inter-byte timeout
//  words_loaded out  9   words written in current/last frame (1..256), cleared at SYNC
// BEHAVIOUR
//  Frame: SYNC, ADDR_HI (bit0 = addr[8], bits7:1 ignored), ADDR_LO, COUNT (N = COUNT+1 words, 1..256),
//   N x 5 data bytes MSB-first (byte0[7:4] ignored, byte0[3:0] = word[35:32]), CSUM.
//  CSUM = 8-bit mod-256 sum of all bytes after SYNC up to the last data byte.
//  Reset (reset_n low at posedge): state IDLE; all outputs 0 except rx_ready=0; counters/accum 0.
//  rx_ready = 1 every cycle after the first cycle out of reset; loader accepts one byte per cycle.
//  FSM: IDLE -> (byte==SYNC_BYTE) ADDR_HI -> ADDR_LO -> COUNT -> DATA -> CSUM -> IDLE.
//   IDLE: non-SYNC bytes discarded silently. SYNC clears words_loaded and checksum accum.
//   DATA: byte index 0..4; on index 4 accepted, word is complete and written; index wraps to 0.
//    After the N-th word, go to CSUM; otherwise stay in DATA.
//   Inside a frame, SYNC_BYTE values are ordinary data (no resync).
//  Write timing: we asserted in the cycle after the 5th byte of a word is accepted (1-cycle latency).
//   addressW/datain registered, valid with we, held until the next write.
//   First word written at the start address; each later word at addressW+1 mod 512 (0x1FF -> 0x000).
//   words_loaded increments in the same cycle we is asserted.
//  CSUM accepted: next cycle load_done=1, csum_err=(rx byte != accum), state IDLE.
//   Writes already issued are never retracted.
//  Timeout: in any non-IDLE state, the idle counter resets on each accepted byte.
//   When TIMEOUT_CYCLES clocks pass without an accepted byte: timeout_err pulse, state IDLE.
//   A partially assembled word is dropped (no we); load_done is not pulsed.
//  A timeout and a byte accepted in the same cycle: the byte wins and the counter restarts.
//  Reset mid-frame: immediate abort to IDLE; no pulses generated; partial word dropped.
//  we is never asserted outside DATA word completion; at most one we per 5 accepted bytes.
// TESTING
//  T1 basic: A5 00 40 00 01 23 45 67 89 99 -> single we, addressW=0x040, datain=36'h1_2345_6789;
//     load_done=1, csum_err=0, words_loaded=1.
//  T2 wrap: A5 01 FF 01 + 2 words + correct csum -> we at 0x1FF then 0x000; words_loaded=2.
//  T3 bad csum: T1 frame with last byte 0x98 -> write still occurs;
//     load_done and csum_err pulse in the same cycle.
//  T4 sync: bytes 00 FF 12 then T1 frame with data byte 0xA5 -> garbage ignored; 0xA5 written as data.
//  T5 timeout: T1 frame stalls after 3 data bytes for TIMEOUT_CYCLES -> timeout_err pulse, no we,
//     busy=0; following T1 frame loads correctly.
//  T6 reset: reset_n low for 1 cycle after COUNT byte -> all outputs 0; next T1 frame loads correctly;
//     back-to-back bytes (rx_valid held high) sustained at 1 byte/cycle.

Source files
------------

// File: rtl/coef_loader_if.sv
// Byte-stream input and coefficient-memory write port of the coefficient loader.
// The slave modport is the loader; the master modport is the byte source / memory side.
interface coef_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [8:0]  addressW;
   logic [35:0] datain;
   logic        we;
   logic        busy;
   logic        load_done;
   logic        csum_err;
   logic        timeout_err;
   logic [8:0]  words_loaded;

   modport master (
      output rx_data,
      output rx_valid,
      input  rx_ready,
      input  addressW,
      input  datain,
      input  we,
      input  busy,
      input  load_done,
      input  csum_err,
      input  timeout_err,
      input  words_loaded
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      output rx_ready,
      output addressW,
      output datain,
      output we,
      output busy,
      output load_done,
      output csum_err,
      output timeout_err,
      output words_loaded
   );
endinterface

// File: rtl/coef_loader.sv
// Framed byte-stream receiver that assembles 36-bit coefficient words and writes them
// into the coefficient memory bank at consecutive addresses.
module coef_loader #(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 50000
) (
   input  logic          clock,
   input  logic          reset_n,
   coef_loader_if.slave  bus
);

   localparam int             CntW    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      ADDR_HI,
      ADDR_LO,
      COUNT,
      DATA,
      CSUM
   } stateT;

   stateT            state;
   logic             rxReadyQ;
   logic             addrHi;
   logic [8:0]       nextAddr;
   logic [7:0]       wordsLeft;
   logic [2:0]       byteIdx;
   logic [27:0]      wordAcc;
   logic [7:0]       accum;
   logic [CntW-1:0]  idleCnt;
   logic [8:0]       addrQ;
   logic [35:0]      dataQ;
   logic             weQ;
   logic             loadDoneQ;
   logic             csumErrQ;
   logic             timeoutErrQ;
   logic [8:0]       wordsQ;
   logic             accept;

   assign accept = bus.rx_valid && rxReadyQ;

   // wordAcc collects the upper 28 bits of a word; the fifth byte completes it straight into dataQ.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state       <= IDLE;
         rxReadyQ    <= 1'b0;
         addrHi      <= 1'b0;
         nextAddr    <= '0;
         wordsLeft   <= '0;
         byteIdx     <= '0;
         wordAcc     <= '0;
         accum       <= '0;
         idleCnt     <= '0;
         addrQ       <= '0;
         dataQ       <= '0;
         weQ         <= 1'b0;
         loadDoneQ   <= 1'b0;
         csumErrQ    <= 1'b0;
         timeoutErrQ <= 1'b0;
         wordsQ      <= '0;
      end else begin
         rxReadyQ    <= 1'b1;
         weQ         <= 1'b0;
         loadDoneQ   <= 1'b0;
         csumErrQ    <= 1'b0;
         timeoutErrQ <= 1'b0;
         if (accept) begin
            idleCnt <= '0;
            unique case (state)
               IDLE: begin
                  if (bus.rx_data == SYNC_BYTE) begin
                     state  <= ADDR_HI;
                     wordsQ <= '0;
                     accum  <= '0;
                  end
               end
               ADDR_HI: begin
                  addrHi <= bus.rx_data[0];
                  accum  <= accum + bus.rx_data;
                  state  <= ADDR_LO;
               end
               ADDR_LO: begin
                  nextAddr <= {addrHi, bus.rx_data};
                  accum    <= accum + bus.rx_data;
                  state    <= COUNT;
               end
               COUNT: begin
                  wordsLeft <= bus.rx_data;
                  byteIdx   <= '0;
                  accum     <= accum + bus.rx_data;
                  state     <= DATA;
               end
               DATA: begin
                  accum <= accum + bus.rx_data;
                  if (byteIdx == 3'd4) begin
                     weQ      <= 1'b1;
                     addrQ    <= nextAddr;
                     dataQ    <= {wordAcc, bus.rx_data};
                     nextAddr <= nextAddr + 9'd1;
                     wordsQ   <= wordsQ + 9'd1;
                     byteIdx  <= '0;
                     if (wordsLeft == 8'd0) begin
                        state <= CSUM;
                     end else begin
                        wordsLeft <= wordsLeft - 8'd1;
                     end
                  end else begin
                     byteIdx <= byteIdx + 3'd1;
                     if (byteIdx == 3'd0) begin
                        wordAcc <= {24'd0, bus.rx_data[3:0]};
                     end else begin
                        wordAcc <= {wordAcc[19:0], bus.rx_data};
                     end
                  end
               end
               CSUM: begin
                  loadDoneQ <= 1'b1;
                  csumErrQ  <= (bus.rx_data != accum);
                  state     <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE) begin
            if (idleCnt == CntLast) begin
               timeoutErrQ <= 1'b1;
               idleCnt     <= '0;
               state       <= IDLE;
            end else begin
               idleCnt <= idleCnt + CntW'(1);
            end
         end
      end
   end

   assign bus.rx_ready     = rxReadyQ;
   assign bus.addressW     = addrQ;
   assign bus.datain       = dataQ;
   assign bus.we           = weQ;
   assign bus.busy         = (state != IDLE);
   assign bus.load_done    = loadDoneQ;
   assign bus.csum_err     = csumErrQ;
   assign bus.timeout_err  = timeoutErrQ;
   assign bus.words_loaded = wordsQ;

endmodule
